// File: rtl/p2s_multi_if.sv
// Bus bundle for p2s_multi: SPI slave pins plus the parallel channel-word side.
interface p2s_multi_if #(
  parameter int NCH  = 4,
  parameter int IN_W = 14
);
  // Handshake: the master drops cs_n to open a frame. It shifts with sck in mode 0
  // (samples miso on rising sck; the slave advances on falling sck). Raising cs_n
  // before the last bit aborts. ch_data/ch_en are taken once, at frame load.
  logic                  sck;
  logic                  cs_n;
  logic [NCH*IN_W-1:0]   ch_data;
  logic [NCH-1:0]        ch_en;
  logic                  miso;
  logic                  miso_oe;
  logic                  busy;
  logic                  frame_done;
  logic                  frame_abort;

  modport master (
    output sck, cs_n, ch_data, ch_en,
    input  miso, miso_oe, busy, frame_done, frame_abort
  );

  modport slave (
    input  sck, cs_n, ch_data, ch_en,
    output miso, miso_oe, busy, frame_done, frame_abort
  );
endinterface

// File: rtl/p2s_multi.sv
// Multi-channel SPI slave serializer, oversampling sck/cs_n in the clk domain.
// Define P2S_PARITY_EN to append an even-parity bit after every channel word.
module p2s_multi #(
  parameter int NCH       = 4,
  parameter int IN_W      = 14,
  parameter int OUT_W     = 11,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  p2s_multi_if.slave    bus,
  output logic [1:0]    dbg_state_o
);
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
`ifdef P2S_PARITY_EN
  localparam int LAST = OUT_W;
`else
  localparam int LAST = OUT_W - 1;
`endif
  localparam int BW = (LAST > 0) ? $clog2(LAST + 1) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT, ST_DONE} state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       ch_idx_q, ch_idx_d;
  logic [BW-1:0]       bit_idx_q, bit_idx_d;
  logic [NCH-1:0]      mask_q, mask_d;
  logic                done_q, done_d;
  logic                abort_q, abort_d;
  logic [OUT_W-1:0]    shadow_q [NCH];

  logic sck_s1_q, sck_s2_q, sck_h_q;
  logic cs_s1_q, cs_s2_q, cs_h_q;
  logic sck_fall, cs_fall, cs_rise;

  logic [OUT_W-1:0]    cur_word, ord_word;
  logic                cur_bit;
  logic [CW:0]         nx;

  assign sck_fall = sck_h_q & ~sck_s2_q;
  assign cs_fall  = cs_h_q & ~cs_s2_q;
  assign cs_rise  = ~cs_h_q & cs_s2_q;

  // Returns {found, index} of the lowest set mask bit at or above start.
  function automatic logic [CW:0] next_ch(input logic [NCH-1:0] m, input int start);
    logic [CW:0] r;
    r = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (m[i] && (i >= start)) r = {1'b1, CW'(i)};
    end
    return r;
  endfunction

  always_comb begin
    cur_word = '0;
    for (int c = 0; c < NCH; c++) begin
      if (int'(ch_idx_q) == c) cur_word = shadow_q[c];
    end
    ord_word = '0;
    for (int i = 0; i < OUT_W; i++) begin
      ord_word[i] = MSB_FIRST ? cur_word[OUT_W-1-i] : cur_word[i];
    end
    cur_bit = 1'b0;
    for (int i = 0; i < OUT_W; i++) begin
      if (int'(bit_idx_q) == i) cur_bit = ord_word[i];
    end
`ifdef P2S_PARITY_EN
    if (int'(bit_idx_q) == OUT_W) cur_bit = ^cur_word;
`endif
  end

  always_comb begin
    state_d   = state_q;
    ch_idx_d  = ch_idx_q;
    bit_idx_d = bit_idx_q;
    mask_d    = mask_q;
    done_d    = 1'b0;
    abort_d   = 1'b0;
    nx        = '0;
    case (state_q)
      ST_IDLE: begin
        if (cs_fall) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (cs_rise) begin
          state_d = ST_IDLE;
          abort_d = 1'b1;
        end else begin
          nx        = next_ch(bus.ch_en, 0);
          mask_d    = bus.ch_en;
          ch_idx_d  = nx[CW-1:0];
          bit_idx_d = '0;
          if (nx[CW]) begin
            state_d = ST_SHIFT;
          end else begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end
      end
      ST_SHIFT: begin
        // Abort takes priority over a coincident sck falling edge.
        if (cs_rise) begin
          state_d = ST_IDLE;
          abort_d = 1'b1;
        end else if (sck_fall) begin
          if (bit_idx_q == BW'(LAST)) begin
            bit_idx_d = '0;
            nx        = next_ch(mask_q, int'(ch_idx_q) + 1);
            if (nx[CW]) begin
              ch_idx_d = nx[CW-1:0];
            end else begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (cs_rise) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ch_idx_q  <= '0;
      bit_idx_q <= '0;
      mask_q    <= '0;
      done_q    <= 1'b0;
      abort_q   <= 1'b0;
      sck_s1_q  <= 1'b0;
      sck_s2_q  <= 1'b0;
      sck_h_q   <= 1'b0;
      cs_s1_q   <= 1'b1;
      cs_s2_q   <= 1'b1;
      cs_h_q    <= 1'b1;
      for (int c = 0; c < NCH; c++) shadow_q[c] <= '0;
    end else begin
      state_q   <= state_d;
      ch_idx_q  <= ch_idx_d;
      bit_idx_q <= bit_idx_d;
      mask_q    <= mask_d;
      done_q    <= done_d;
      abort_q   <= abort_d;
      sck_s1_q  <= bus.sck;
      sck_s2_q  <= sck_s1_q;
      sck_h_q   <= sck_s2_q;
      cs_s1_q   <= bus.cs_n;
      cs_s2_q   <= cs_s1_q;
      cs_h_q    <= cs_s2_q;
      if (state_q == ST_LOAD) begin
        for (int c = 0; c < NCH; c++) shadow_q[c] <= bus.ch_data[c*IN_W+IN_W-1 -: OUT_W];
      end
    end
  end

  assign bus.miso        = (state_q == ST_SHIFT) ? cur_bit : 1'b0;
  assign bus.miso_oe     = (state_q != ST_IDLE);
  assign bus.busy        = (state_q == ST_LOAD) || (state_q == ST_SHIFT);
  assign bus.frame_done  = done_q;
  assign bus.frame_abort = abort_q;
  assign dbg_state_o     = state_q;
endmodule

// File: tb/tb_p2s_multi.sv
// Randomized bench for p2s_multi: an MSB-first and an LSB-first instance share one SPI master.
module tb_p2s_multi;
  localparam int NCH  = 4;
  localparam int IN_W = 14;
  localparam int OUT_W = 11;
`ifdef P2S_PARITY_EN
  localparam int FW = OUT_W + 1;
`else
  localparam int FW = OUT_W;
`endif
  localparam int HALF = 8;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic                sck;
  logic                cs_n;
  logic [NCH*IN_W-1:0] ch_data;
  logic [NCH-1:0]      ch_en;
  logic [1:0]          dbg_m, dbg_l;

  p2s_multi_if #(.NCH(NCH), .IN_W(IN_W)) bus_m ();
  p2s_multi_if #(.NCH(NCH), .IN_W(IN_W)) bus_l ();

  assign bus_m.sck = sck;     assign bus_l.sck = sck;
  assign bus_m.cs_n = cs_n;   assign bus_l.cs_n = cs_n;
  assign bus_m.ch_data = ch_data; assign bus_l.ch_data = ch_data;
  assign bus_m.ch_en = ch_en; assign bus_l.ch_en = ch_en;

  p2s_multi #(.NCH(NCH), .IN_W(IN_W), .OUT_W(OUT_W), .MSB_FIRST(1'b1)) u_dut_msb (
    .clk(clk), .rst(rst), .bus(bus_m), .dbg_state_o(dbg_m)
  );
  p2s_multi #(.NCH(NCH), .IN_W(IN_W), .OUT_W(OUT_W), .MSB_FIRST(1'b0)) u_dut_lsb (
    .clk(clk), .rst(rst), .bus(bus_l), .dbg_state_o(dbg_l)
  );

  // scoreboard
  int n_checks = 0;
  int n_fail = 0;
  logic [0:0] exp_m_q[$];
  logic [0:0] exp_l_q[$];
  logic [0:0] cap_m_q[$];
  logic [0:0] cap_l_q[$];

  int done_m, done_l, abort_m, abort_l, done_at_m, n_fall;

  always @(negedge clk) begin
    if (bus_m.frame_done) begin done_m++; done_at_m = n_fall; end
    if (bus_l.frame_done) done_l++;
    if (bus_m.frame_abort) abort_m++;
    if (bus_l.frame_abort) abort_l++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [NCH*IN_W-1:0] rand_data();
    logic [NCH*IN_W-1:0] d;
    for (int c = 0; c < NCH; c++) d[c*IN_W +: IN_W] = IN_W'($urandom_range(0, (1 << IN_W) - 1));
    return d;
  endfunction

  // Reference: the bit stream a mode-0 master should capture for this load.
  task automatic build_expected(input logic [NCH*IN_W-1:0] d, input logic [NCH-1:0] m);
    logic [IN_W-1:0]  word;
    logic [OUT_W-1:0] w;
    exp_m_q.delete();
    exp_l_q.delete();
    for (int c = 0; c < NCH; c++) begin
      if (m[c]) begin
        word = d[c*IN_W +: IN_W];
        w = OUT_W'(word >> (IN_W - OUT_W));
        for (int i = OUT_W - 1; i >= 0; i--) exp_m_q.push_back(w[i]);
        for (int i = 0; i < OUT_W; i++) exp_l_q.push_back(w[i]);
`ifdef P2S_PARITY_EN
        exp_m_q.push_back(^w);
        exp_l_q.push_back(^w);
`endif
      end
    end
  endtask

  function automatic logic [OUT_W-1:0] cap_word_msb(input int k);
    logic [OUT_W-1:0] w;
    w = '0;
    for (int j = 0; j < OUT_W; j++) w = {w[OUT_W-2:0], cap_m_q[k*FW + j]};
    return w;
  endfunction

  function automatic logic [OUT_W-1:0] cap_word_lsb(input int k);
    logic [OUT_W-1:0] w;
    w = '0;
    for (int j = 0; j < OUT_W; j++) w[j] = cap_l_q[k*FW + j];
    return w;
  endfunction

  // Driver: one chip-select transaction; nfall < 0 runs the complete frame.
  task automatic run_frame(input logic [NCH*IN_W-1:0] d, input logic [NCH-1:0] m, input int nfall);
    int total, nf;
    bit complete;
    logic [0:0] em, el;
    build_expected(d, m);
    total = exp_m_q.size();
    nf = (nfall < 0) ? total : nfall;
    complete = (nf == total);
    cap_m_q.delete();
    cap_l_q.delete();
    done_m = 0; done_l = 0; abort_m = 0; abort_l = 0; done_at_m = -1; n_fall = 0;
    @(negedge clk);
    ch_data = d;
    ch_en = m;
    cs_n = 1'b0;
    wait_clk(HALF);
    check("busy_after_load", 32'(bus_m.busy), (total == 0) ? 32'd0 : 32'd1);
    check("oe_after_load", 32'(bus_m.miso_oe), 32'd1);
    if (total == 0) begin
      check("empty_done_m", done_m, 1);
      check("empty_done_l", done_l, 1);
      check("empty_miso", 32'(bus_m.miso), 32'd0);
    end
    ch_data = rand_data();
    ch_en = NCH'($urandom_range(0, (1 << NCH) - 1));
    for (int k = 0; k < nf; k++) begin
      em = (exp_m_q.size() > 0) ? exp_m_q.pop_front() : 1'b0;
      el = (exp_l_q.size() > 0) ? exp_l_q.pop_front() : 1'b0;
      check("miso_msb", 32'(bus_m.miso), 32'(em));
      check("miso_lsb", 32'(bus_l.miso), 32'(el));
      cap_m_q.push_back(bus_m.miso);
      cap_l_q.push_back(bus_l.miso);
      sck = 1'b1;
      wait_clk(HALF);
      sck = 1'b0;
      n_fall++;
      wait_clk(HALF);
    end
    if (complete) begin
      check("done_count_m", done_m, 1);
      check("done_count_l", done_l, 1);
      check("done_at_fall", done_at_m, total);
      check("busy_in_done", 32'(bus_m.busy), 32'd0);
      check("miso_in_done", 32'(bus_m.miso) | 32'(bus_l.miso), 32'd0);
      check("oe_in_done", 32'(bus_m.miso_oe), 32'd1);
    end
    cs_n = 1'b1;
    wait_clk(HALF);
    check("abort_count_m", abort_m, complete ? 0 : 1);
    check("abort_count_l", abort_l, complete ? 0 : 1);
    check("done_after_cs", done_m, complete ? 1 : 0);
    check("oe_idle", 32'(bus_m.miso_oe) | 32'(bus_l.miso_oe), 32'd0);
    check("busy_idle", 32'(bus_m.busy), 32'd0);
    check("miso_idle", 32'(bus_m.miso), 32'd0);
  endtask

  localparam logic [NCH*IN_W-1:0] KAT_DATA = {14'h1555, 14'h2AA8, 14'h0000, 14'h3FFF};

  initial begin
    logic [OUT_W-1:0] kat [NCH];
    logic [NCH*IN_W-1:0] d;
    logic [NCH-1:0] m;
    int tot;
    kat[0] = 11'h7FF; kat[1] = 11'h000; kat[2] = 11'h555; kat[3] = 11'h2AA;
    rst = 1'b1; sck = 1'b0; cs_n = 1'b1; ch_data = '0; ch_en = '0;
    done_m = 0; done_l = 0; abort_m = 0; abort_l = 0; n_fall = 0; done_at_m = -1;
    wait_clk(2);
    check("reset_miso", 32'(bus_m.miso), 32'd0);
    check("reset_oe", 32'(bus_m.miso_oe), 32'd0);
    check("reset_busy", 32'(bus_m.busy), 32'd0);
    rst = 1'b0;

    // sck activity without chip select must be ignored
    for (int i = 0; i < 4; i++) begin
      sck = ~sck;
      wait_clk(HALF);
      check("idle_outputs", {29'd0, bus_m.miso, bus_m.miso_oe, bus_m.busy}, 32'd0);
    end
    check("idle_pulses", done_m + abort_m + done_l + abort_l, 0);

    // known-answer full frame
    run_frame(KAT_DATA, 4'hF, -1);
    for (int k = 0; k < NCH; k++) check("kat_word", 32'(cap_word_msb(k)), 32'(kat[k]));

    // masked frame: channels 1 and 3 only
    run_frame(KAT_DATA, 4'b1010, -1);
    check("mask_word0", 32'(cap_word_msb(0)), 32'h000);
    check("mask_word1", 32'(cap_word_msb(1)), 32'h2AA);

    // empty mask
    run_frame(KAT_DATA, 4'h0, -1);

    // abort after 17 falling edges, then a fresh frame from channel 0
    run_frame(KAT_DATA, 4'hF, 17);
    run_frame(KAT_DATA, 4'hF, -1);
    check("restart_word0", 32'(cap_word_msb(0)), 32'h7FF);

    // LSB-first: ch0 = 14'h0008 sends word 11'h001
    d = rand_data();
    d[IN_W-1:0] = 14'h0008;
    run_frame(d, 4'h1, -1);
    check("lsb_first_bit", 32'(cap_l_q[0]), 32'd1);
    check("lsb_word", 32'(cap_word_lsb(0)), 32'h001);

    // randomized complete and aborted frames
    for (int r = 0; r < 6; r++) run_frame(rand_data(), NCH'($urandom_range(0, (1 << NCH) - 1)), -1);
    for (int r = 0; r < 3; r++) begin
      m = NCH'($urandom_range(1, (1 << NCH) - 1));
      d = rand_data();
      build_expected(d, m);
      tot = exp_m_q.size();
      run_frame(d, m, $urandom_range(1, tot - 1));
    end

    // reset in the middle of a frame: no pulses, outputs back to zero
    @(negedge clk);
    ch_data = rand_data(); ch_en = 4'hF; cs_n = 1'b0;
    wait_clk(HALF);
    for (int i = 0; i < 5; i++) begin
      sck = 1'b1; wait_clk(HALF); sck = 1'b0; wait_clk(HALF);
    end
    check("pre_reset_busy", 32'(bus_m.busy), 32'd1);
    done_m = 0; done_l = 0; abort_m = 0; abort_l = 0;
    rst = 1'b1; cs_n = 1'b1;
    wait_clk(1);
    check("midreset_outputs", {29'd0, bus_m.miso, bus_m.miso_oe, bus_m.busy}, 32'd0);
    wait_clk(1);
    rst = 1'b0;
    wait_clk(HALF);
    check("midreset_pulses", done_m + abort_m + done_l + abort_l, 0);
    check("midreset_idle", {29'd0, bus_l.miso, bus_l.miso_oe, bus_l.busy}, 32'd0);

    // normal operation resumes after reset
    run_frame(rand_data(), 4'hF, -1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/p2s_multi.md
Name: p2s_multi

Overview:
- Parametrised successor to the single-channel SPI slave serializer: frames NCH channel words onto one MISO line per chip-select transaction.
- Runs entirely in the system clk domain. Oversamples sck and cs_n through synchronisers instead of clocking logic on sck.
- Sits between the per-channel delay/measurement datapath and the external SPI master. Supports a per-frame channel mask, selectable bit order and word truncation.

Parameters:
- NCH, 4, number of channels serialized per frame (1..16).
- IN_W, 14, width of each input channel word.
- OUT_W, 11, bits sent per channel; the top OUT_W bits of each word are sent (OUT_W <= IN_W).
- MSB_FIRST, 1, 1 = MSB of the truncated word first; 0 = LSB first.

Ports:
- clk  in  1  system clock; must be >= 8x sck frequency.
- rst  in  1  synchronous, active-high reset.
- sck  in  1  SPI clock from master; mode 0: master samples on rising edge, slave shifts on falling edge.
- cs_n  in  1  SPI chip select, active low.
- ch_data  in  NCH*IN_W  channel words, channel c at [c*IN_W +: IN_W].
- ch_en  in  NCH  channel enable mask; a 0 bit skips that channel.
- miso  out  1  serial data.
- miso_oe  out  1  output enable for the MISO pad driver.
- busy  out  1  high from load until frame end or abort.
- frame_done  out  1  one-clk pulse after the last bit of a completed frame.
- frame_abort  out  1  one-clk pulse when cs_n rises before frame completion.

Behaviour:
- Reset (rst=1 at a clk edge): all outputs 0, state IDLE, shadow registers 0, synchroniser flops set to sck=0 and cs_n=1.
- Synchronisation:
  - sck and cs_n each pass through 2 flops, then 1 history flop for edge detection.
  - Edge-to-action latency is 3 clk.
- State IDLE: miso=0, miso_oe=0, busy=0.
  - Synchronised cs_n falling edge -> LOAD.
- State LOAD (1 clk):
  - Shadow[c] <= ch_data[c*IN_W+IN_W-1 -: OUT_W] for every c.
  - Mask <= ch_en.
  - Channel index <= lowest enabled channel; bit index <= 0.
  - busy=1, miso_oe=1.
  - If mask == 0: go to DONE and pulse frame_done in the next clk. Otherwise -> SHIFT.
- State SHIFT:
  - miso continuously presents the current bit of the current channel: bit OUT_W-1-bit_idx if MSB_FIRST, else bit bit_idx.
  - On each synchronised sck falling edge, bit_idx increments.
  - When bit_idx reaches OUT_W-1 and another falling edge arrives: bit_idx <= 0 and channel index moves to the next enabled channel (ascending).
  - If no enabled channel remains: -> DONE with a one-clk frame_done pulse, and miso=0.
  - Sck rising edges are ignored. Total falling edges per frame = popcount(mask)*OUT_W (plus parity bits, see below).
- State DONE: busy=0, miso=0, miso_oe=1.
  - Further sck edges are ignored.
  - Synchronised cs_n rising edge -> IDLE (miso_oe=0).
- Abort: a cs_n rising edge in LOAD or SHIFT -> IDLE in the same cycle.
  - Outputs: frame_abort pulse, frame_done not asserted, busy=0, miso=0, miso_oe=0.
  - The next cs_n fall starts a fresh frame.
- ch_data and ch_en changes after LOAD have no effect on the frame in progress.
- Simultaneous sck falling edge and cs_n rising edge in the same clk: the abort wins.
- A cs_n fall while not in IDLE is impossible without a preceding rise, which is handled as above.
- rst mid-frame: immediate return to reset values on the next clk edge. No pulses are generated.

Optional Feature:
- Macro P2S_PARITY_EN.
- Defined: after the last data bit of each channel, one extra bit is sent equal to the even parity (XOR) of that channel's OUT_W sent bits. The channel advances on the falling edge following the parity bit. Frame length = popcount(mask)*(OUT_W+1).
- Undefined: no parity bits; frame length = popcount(mask)*OUT_W. No parity logic is present.

Test Plan:
- Reset then idle: hold rst 2 clk, toggle sck with cs_n=1 -> miso=0, miso_oe=0, busy=0 throughout, no pulses.
- Full frame: NCH=4, OUT_W=11, MSB_FIRST=1, ch_data words 14'h3FFF, 14'h0000, 14'h2AA8, 14'h1555, ch_en=4'hF, 44 sck cycles -> master captures 11'h7FF, 11'h000, 11'h555, 11'h2AA. frame_done pulses once, after the 44th falling edge.
- Mask skip: ch_en=4'b1010, same data -> 22 bits received: 11'h000 then 11'h2AA. frame_done after the 22nd falling edge. ch_en=4'h0 -> frame_done 1 clk after LOAD, miso=0.
- Abort: cs_n rises after 17 sck falling edges -> frame_abort pulse, miso_oe=0. The next frame restarts at channel 0 bit 10.
- LSB_FIRST (MSB_FIRST=0), ch_data[0]=14'h0008 (sent word 11'h001) -> the first bit on miso is 1, followed by ten 0s.
- P2S_PARITY_EN defined, ch0 sent word 11'h007 -> 12 bits per channel, 12th bit=1. For 11'h003 the 12th bit=0.
